// File: rtl/sparse_buffer_writer_if.sv
// sparse_buffer_writer_if: dense-input, buffer-write and status signals of the sparse buffer writer
// prune_thresh exists only when SPARSE_WR_PRUNE_EN is defined.
interface sparse_buffer_writer_if #(parameter int DATA_W = 8, parameter int ADDR_W = 6, parameter int IDX_W = 8);
  logic start, mcc_busy, in_valid, in_ready, in_last;
  logic [DATA_W-1:0] in_data;
  logic wr_en, overflow, done;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [IDX_W-1:0] wr_index;
  logic [7:0] nz_count;
`ifdef SPARSE_WR_PRUNE_EN
  logic [DATA_W-1:0] prune_thresh;
`endif
  modport master (
`ifdef SPARSE_WR_PRUNE_EN
    output prune_thresh,
`endif
    output start, mcc_busy, in_valid, in_data, in_last,
    input in_ready, wr_en, wr_addr, wr_data, wr_index, nz_count, overflow, done
  );
  modport slave (
`ifdef SPARSE_WR_PRUNE_EN
    input prune_thresh,
`endif
    input start, mcc_busy, in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_data, wr_index, nz_count, overflow, done
  );
endinterface

// File: rtl/sparse_buffer_writer.sv
// sparse_buffer_writer: drops zeros from a dense stream, writes nonzero value+index to the sparse buffer
// SPARSE_WR_PRUNE_EN adds a magnitude threshold below which values count as zero.
module sparse_buffer_writer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int IDX_W = 8
) (
  input logic clk,
  input logic reset,
  sparse_buffer_writer_if.slave bus
);
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t state;
  logic [ADDR_W:0] ptr;
  logic [IDX_W-1:0] pos;
  logic accept, keep;
  assign bus.in_ready = (state == FILL) && !bus.mcc_busy;
  assign accept = bus.in_valid && bus.in_ready;
`ifdef SPARSE_WR_PRUNE_EN
  localparam logic [DATA_W-1:0] MIN = {1'b1, {(DATA_W-1){1'b0}}};
  logic [DATA_W-1:0] mag;
  // the most negative value has no positive twin, so its magnitude saturates
  assign mag = !bus.in_data[DATA_W-1] ? bus.in_data : (bus.in_data == MIN) ? ~MIN : -bus.in_data;
  assign keep = mag > bus.prune_thresh;
`else
  assign keep = |bus.in_data;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      pos <= '0;
      bus.wr_en <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.wr_index <= '0;
      bus.nz_count <= '0;
      bus.overflow <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start && !bus.mcc_busy) begin
          state <= FILL;
          ptr <= '0;
          pos <= '0;
          bus.nz_count <= '0;
          bus.overflow <= 1'b0;
        end
        FILL: if (accept) begin
          pos <= pos + 1'b1;
          if (keep && ptr != FULL) begin
            bus.wr_en <= 1'b1;
            bus.wr_addr <= ptr[ADDR_W-1:0];
            bus.wr_data <= bus.in_data;
            bus.wr_index <= pos;
            ptr <= ptr + 1'b1;
            bus.nz_count <= 8'(ptr + 1'b1);
          end else if (keep) bus.overflow <= 1'b1;
          if (bus.in_last) begin
            state <= DONE;
            bus.done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
